run_sequencer: RTL and testbench

Host-side run controller for the 8-bit accumulator processor core: drives the core's `start` input and watches its `halt` output. On a host request it runs a fixed number of programs back-to-back, selecting each through `prog_sel` and giving each a start pulse. It measures each program's execution cycles, flags runaways with a watchdog, and reports one result record per program plus a completion pulse.

---
 rtl/run_sequencer.sv | 147 ++++++++++++++
 tb/tb_run_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Host-side run controller for the 8-bit accumulator core.
// Launches NUM_PROGS programs back-to-back and measures each one's cycle count.
// A watchdog ends any program that runs too long, and the block reports one
// result record per program.
module run_sequencer #(
  parameter int unsigned NUM_PROGS    = 3,
  parameter int unsigned PSEL_W       = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TIMEOUT      = 16'hFFFF,
  parameter int unsigned START_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req,
  input  logic              abort,
  input  logic              halt,
  output logic              start,
  output logic [PSEL_W-1:0] prog_sel,
  output logic              busy,
  output logic              result_valid,
  output logic [PSEL_W-1:0] result_prog,
  output logic [CNT_W-1:0]  result_cycles,
  output logic              result_timeout,
  output logic              done,
  output logic              error
);

  localparam int unsigned SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0]   ScLast     = SC_W'(START_CYCLES - 1);
  localparam logic [PSEL_W-1:0] ProgLast   = PSEL_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0]  CntLast    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CntTimeout = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StStart, StRun, StRecord, StDone} state_e;

  state_e            stateQ, stateD;
  logic [SC_W-1:0]   scntQ, scntD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic [PSEL_W-1:0] progSelD, resProgD;
  logic [CNT_W-1:0]  resCyclesD;
  logic              resTimeoutD, errorD, startD, busyD, resValidD, doneD;

  // Next-state, counters and result capture; outputs decoded from the next state
  always_comb begin
    stateD      = stateQ;
    scntD       = scntQ;
    cntD        = cntQ;
    progSelD    = prog_sel;
    resProgD    = result_prog;
    resCyclesD  = result_cycles;
    resTimeoutD = result_timeout;
    errorD      = error;
    unique case (stateQ)
      StIdle: begin
        if (req) begin
          progSelD = '0;
          errorD   = 1'b0;
          cntD     = '0;
          scntD    = '0;
          stateD   = StStart;
        end
      end
      StStart: begin
        if (abort) begin
          stateD = StIdle;
        end else if (scntQ == ScLast) begin
          stateD = StRun;
        end else begin
          scntD = scntQ + 1'b1;
        end
      end
      StRun: begin
        // cntQ == 0 only on the first RUN cycle, where a stale halt is ignored
        if (abort) begin
          stateD = StIdle;
        end else if (halt && (cntQ != '0)) begin
          resCyclesD  = cntQ;
          resTimeoutD = 1'b0;
          resProgD    = prog_sel;
          stateD      = StRecord;
        end else if (cntQ == CntLast) begin
          resCyclesD  = CntTimeout;
          resTimeoutD = 1'b1;
          resProgD    = prog_sel;
          errorD      = 1'b1;
          stateD      = StRecord;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      StRecord: begin
        if (abort) begin
          stateD = StIdle;
        end else if (prog_sel == ProgLast) begin
          stateD = StDone;
        end else begin
          progSelD = prog_sel + 1'b1;
          cntD     = '0;
          scntD    = '0;
          stateD   = StStart;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
    startD    = (stateD == StStart);
    busyD     = (stateD == StStart) || (stateD == StRun) || (stateD == StRecord);
    resValidD = (stateD == StRecord);
    doneD     = (stateD == StDone);
  end

  // State, counters and all registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stateQ         <= StIdle;
      scntQ          <= '0;
      cntQ           <= '0;
      start          <= 1'b0;
      prog_sel       <= '0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_prog    <= '0;
      result_cycles  <= '0;
      result_timeout <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      stateQ         <= stateD;
      scntQ          <= scntD;
      cntQ           <= cntD;
      start          <= startD;
      prog_sel       <= progSelD;
      busy           <= busyD;
      result_valid   <= resValidD;
      result_prog    <= resProgD;
      result_cycles  <= resCyclesD;
      result_timeout <= resTimeoutD;
      done           <= doneD;
      error          <= errorD;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: default instance plus a TIMEOUT=8 instance
// for the watchdog scenario.
module tb_run_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N, req, abort, halt;
  logic wReq, wAbort, wHalt;

  logic        start, busy, result_valid, result_timeout, done, error;
  logic [1:0]  prog_sel, result_prog;
  logic [15:0] result_cycles;

  logic        wStart, wBusy, wValid, wTimeout, wDone, wError;
  logic [1:0]  wProgSel, wProg;
  logic [15:0] wCycles;

  logic [4:0] flags;
  assign flags = {start, busy, result_valid, done, error};

  int nVec = 0;
  int nErr = 0;

  run_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .abort(abort), .halt(halt),
    .start(start), .prog_sel(prog_sel), .busy(busy), .result_valid(result_valid),
    .result_prog(result_prog), .result_cycles(result_cycles),
    .result_timeout(result_timeout), .done(done), .error(error)
  );

  run_sequencer #(.TIMEOUT(8)) dutWd (
    .CLK(CLK), .RST_N(RST_N), .req(wReq), .abort(wAbort), .halt(wHalt),
    .start(wStart), .prog_sel(wProgSel), .busy(wBusy), .result_valid(wValid),
    .result_prog(wProg), .result_cycles(wCycles),
    .result_timeout(wTimeout), .done(wDone), .error(wError)
  );

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Runs one program from its first START cycle; halt rises on RUN cycle haltCycle
  task automatic run_one(input int haltCycle, input int expProg, input int expCycles,
                         input bit pulseReq);
    nVec++;
    if (flags[4:1] !== 4'b1100 || prog_sel !== 2'(expProg)) begin
      nErr++;
      $display("FAIL run_start1 p%0d: flags=%b sel=%0d, want 1100 sel=%0d",
               expProg, flags[4:1], prog_sel, expProg);
    end
    step;
    nVec++;
    if (flags[4:1] !== 4'b1100) begin
      nErr++;
      $display("FAIL run_start2 p%0d: flags=%b, want 1100", expProg, flags[4:1]);
    end
    step;
    nVec++;
    if (flags[4:1] !== 4'b0100) begin
      nErr++;
      $display("FAIL run_first p%0d: flags=%b, want 0100", expProg, flags[4:1]);
    end
    if (pulseReq) req = 1'b1;
    for (int i = 1; i < haltCycle; i++) begin
      step;
      if (pulseReq) req = 1'b0;
    end
    nVec++;
    if (flags[4:1] !== 4'b0100) begin
      nErr++;
      $display("FAIL run_halt_cycle p%0d: flags=%b, want 0100", expProg, flags[4:1]);
    end
    halt = 1'b1;
    step;
    halt = 1'b0;
    nVec++;
    if (flags[4:1] !== 4'b0110 || result_prog !== 2'(expProg) ||
        result_cycles !== 16'(expCycles) || result_timeout !== 1'b0) begin
      nErr++;
      $display("FAIL run_record p%0d: flags=%b prog=%0d cyc=%0d to=%b, want 0110 %0d %0d 0",
               expProg, flags[4:1], result_prog, result_cycles, result_timeout,
               expProg, expCycles);
    end
    step;
  endtask

  task automatic test_reset;
    RST_N = 1'b1; req = 0; abort = 0; halt = 0; wReq = 0; wAbort = 0; wHalt = 0;
    #1 RST_N = 1'b0;
    #2;
    nVec++;
    if ({flags, prog_sel, result_prog, result_cycles, result_timeout} !== '0 ||
        {wStart, wBusy, wError} !== 3'b000) begin
      nErr++;
      $display("FAIL reset_state: flags=%b sel=%0d prog=%0d cyc=%0d to=%b, want all 0",
               flags, prog_sel, result_prog, result_cycles, result_timeout);
    end
    step;
    step;
    @(negedge CLK);
    RST_N = 1'b1;
    step;
    nVec++;
    if (flags !== 5'b00000) begin
      nErr++;
      $display("FAIL reset_idle: flags=%b, want 00000", flags);
    end
  endtask

  task automatic test_normal_runs;
    req = 1'b1;
    step;
    req = 1'b0;
    run_one(11, 0, 10, 0);
    run_one(5, 1, 4, 0);
    run_one(2, 2, 1, 0);
    nVec++;
    if (flags !== 5'b00010) begin
      nErr++;
      $display("FAIL done_pulse: flags=%b, want 00010", flags);
    end
    step;
    nVec++;
    if (flags !== 5'b00000) begin
      nErr++;
      $display("FAIL after_done: flags=%b, want 00000", flags);
    end
    step;
    nVec++;
    if (flags !== 5'b00000 || result_prog !== 2'd2 || result_cycles !== 16'd1) begin
      nErr++;
      $display("FAIL result_hold: flags=%b prog=%0d cyc=%0d, want 00000 2 1",
               flags, result_prog, result_cycles);
    end
  endtask

  task automatic test_stale_halt;
    halt = 1'b1;
    req  = 1'b1;
    step;
    req = 1'b0;
    step;
    step;
    step;
    // Stale halt was high through the first RUN cycle; still running here
    nVec++;
    if (flags[4:1] !== 4'b0100) begin
      nErr++;
      $display("FAIL stale_blank: flags=%b, want 0100", flags[4:1]);
    end
    halt = 1'b0;
    step;
    step;
    halt = 1'b1;
    step;
    halt = 1'b0;
    nVec++;
    if (flags[4:1] !== 4'b0110 || result_prog !== 2'd0 || result_cycles !== 16'd3 ||
        result_timeout !== 1'b0) begin
      nErr++;
      $display("FAIL stale_record: flags=%b prog=%0d cyc=%0d to=%b, want 0110 0 3 0",
               flags[4:1], result_prog, result_cycles, result_timeout);
    end
    step;
  endtask

  task automatic test_abort;
    nVec++;
    if (flags[4:1] !== 4'b1100 || prog_sel !== 2'd1) begin
      nErr++;
      $display("FAIL abort_p1_start: flags=%b sel=%0d, want 1100 1", flags[4:1], prog_sel);
    end
    step;
    step;
    step;
    step;
    abort = 1'b1;
    step;
    abort = 1'b0;
    nVec++;
    if (flags !== 5'b00000) begin
      nErr++;
      $display("FAIL abort_idle: flags=%b, want 00000", flags);
    end
    for (int i = 0; i < 4; i++) begin
      step;
      nVec++;
      if (flags !== 5'b00000 || result_cycles !== 16'd3) begin
        nErr++;
        $display("FAIL abort_quiet c%0d: flags=%b cyc=%0d, want 00000 3", i, flags,
                 result_cycles);
      end
    end
  endtask

  task automatic test_reset_relaunch;
    req = 1'b1;
    step;
    nVec++;
    if (flags !== 5'b11000) begin
      nErr++;
      $display("FAIL pre_reset_start: flags=%b, want 11000", flags);
    end
    #2 RST_N = 1'b0;
    #1;
    nVec++;
    if ({flags, prog_sel, result_prog, result_cycles, result_timeout} !== '0) begin
      nErr++;
      $display("FAIL reset_async: flags=%b sel=%0d cyc=%0d, want all 0",
               flags, prog_sel, result_cycles);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    step;
    req = 1'b0;
    nVec++;
    if (flags !== 5'b11000 || prog_sel !== 2'd0) begin
      nErr++;
      $display("FAIL relaunch_s1: flags=%b sel=%0d, want 11000 0", flags, prog_sel);
    end
    step;
    nVec++;
    if (flags !== 5'b11000) begin
      nErr++;
      $display("FAIL relaunch_s2: flags=%b, want 11000", flags);
    end
    step;
    nVec++;
    if (flags !== 5'b01000) begin
      nErr++;
      $display("FAIL relaunch_run: flags=%b, want 01000", flags);
    end
    abort = 1'b1;
    step;
    abort = 1'b0;
  endtask

  task automatic test_watchdog;
    wReq = 1'b1;
    step;
    wReq = 1'b0;
    step;
    step;
    for (int i = 0; i < 7; i++) step;
    nVec++;
    if (wValid !== 1'b0 || wBusy !== 1'b1 || wStart !== 1'b0) begin
      nErr++;
      $display("FAIL wd_run8: valid=%b busy=%b start=%b, want 0 1 0", wValid, wBusy, wStart);
    end
    step;
    nVec++;
    if (wValid !== 1'b1 || wCycles !== 16'd8 || wTimeout !== 1'b1 || wError !== 1'b1 ||
        wProg !== 2'd0) begin
      nErr++;
      $display("FAIL wd_record: valid=%b cyc=%0d to=%b err=%b prog=%0d, want 1 8 1 1 0",
               wValid, wCycles, wTimeout, wError, wProg);
    end
    step;
    nVec++;
    if (wStart !== 1'b1 || wProgSel !== 2'd1 || wError !== 1'b1) begin
      nErr++;
      $display("FAIL wd_continue: start=%b sel=%0d err=%b, want 1 1 1", wStart, wProgSel,
               wError);
    end
    wAbort = 1'b1;
    step;
    wAbort = 1'b0;
    nVec++;
    if (wBusy !== 1'b0 || wError !== 1'b1 || wDone !== 1'b0) begin
      nErr++;
      $display("FAIL wd_abort: busy=%b err=%b done=%b, want 0 1 0", wBusy, wError, wDone);
    end
  endtask

  task automatic test_back_to_back;
    req = 1'b1;
    step;
    run_one(2, 0, 1, 0);
    run_one(3, 1, 2, 0);
    run_one(2, 2, 1, 0);
    nVec++;
    if (flags !== 5'b00010) begin
      nErr++;
      $display("FAIL cont_done: flags=%b, want 00010", flags);
    end
    step;
    nVec++;
    if (flags !== 5'b00000) begin
      nErr++;
      $display("FAIL cont_idle: flags=%b, want 00000", flags);
    end
    step;
    req = 1'b0;
    // Second sequence; a req pulse mid-run must not disturb it
    run_one(2, 0, 1, 0);
    run_one(2, 1, 1, 1);
    run_one(4, 2, 3, 0);
    nVec++;
    if (flags !== 5'b00010) begin
      nErr++;
      $display("FAIL cont_done2: flags=%b, want 00010", flags);
    end
    for (int i = 0; i < 3; i++) begin
      step;
      nVec++;
      if (flags !== 5'b00000) begin
        nErr++;
        $display("FAIL cont_stay_idle c%0d: flags=%b, want 00000", i, flags);
      end
    end
  endtask

  initial begin
    test_reset;
    test_normal_runs;
    test_stale_halt;
    test_abort;
    test_reset_relaunch;
    test_watchdog;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
